// File: rtl/dzcpu_useq_pkg.sv
// dzcpu micro-sequencer shared definitions:
// flow codes, CB-redirect operation, state encoding and ROM word layout.
package dzcpu_useq_defs;

    localparam logic [3:0] FLOW_OP           = 4'd0;
    localparam logic [3:0] FLOW_INC          = 4'd1;
    localparam logic [3:0] FLOW_EOF          = 4'd2;
    localparam logic [3:0] FLOW_INC_EOF      = 4'd3;
    localparam logic [3:0] FLOW_EOF_FU       = 4'd4;
    localparam logic [3:0] FLOW_INC_EOF_FU   = 4'd5;
    localparam logic [3:0] FLOW_INC_EOF_Z    = 4'd6;
    localparam logic [3:0] FLOW_INC_EOF_NZ   = 4'd7;
    localparam logic [3:0] FLOW_UPDATE_FLAGS = 4'd8;
    localparam logic [3:0] FLOW_NOP          = 4'd9;

    localparam logic [4:0] OP_JCB = 5'h1f;

    localparam int FLOW_HI = 12;
    localparam int FLOW_LO = 9;
    localparam int OP_HI   = 8;
    localparam int OP_LO   = 4;
    localparam int OPR_HI  = 3;
    localparam int OPR_LO  = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_RUN      = 2'd2
    } useq_state_t;

endpackage

// File: rtl/dzcpu_useq_flowdec.sv
// Flow-code decoder: maps a uop flow code and the Z flag
// to the PC-increment, end-of-flow and flags-update strobes.
module dzcpu_useq_flowdec
    import dzcpu_useq_defs::*;
(
    input  logic [3:0] flow,
    input  logic       zflag,
    output logic       inc,
    output logic       eof,
    output logic       fu
);

    always_comb begin
        inc = 1'b0;
        eof = 1'b0;
        fu  = 1'b0;
        case (flow)
            FLOW_INC: begin
                inc = 1'b1;
            end
            FLOW_EOF: begin
                eof = 1'b1;
            end
            FLOW_INC_EOF: begin
                inc = 1'b1;
                eof = 1'b1;
            end
            FLOW_EOF_FU: begin
                eof = 1'b1;
                fu  = 1'b1;
            end
            FLOW_INC_EOF_FU: begin
                inc = 1'b1;
                eof = 1'b1;
                fu  = 1'b1;
            end
            FLOW_INC_EOF_Z: begin
                inc = 1'b1;
                eof = zflag;
            end
            FLOW_INC_EOF_NZ: begin
                inc = 1'b1;
                eof = ~zflag;
            end
            FLOW_UPDATE_FLAGS: begin
                fu = 1'b1;
            end
            // FLOW_OP, FLOW_NOP and unassigned codes carry no strobe
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: latches an opcode, looks up its flow,
// then issues one registered uop per cycle until end of flow.
module dzcpu_useq
    import dzcpu_useq_defs::*;
#(
    parameter int MAX_FLOW_LEN = 16,
    parameter int UPC_W        = 8
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iMopValid,
    input  logic [7:0]       iMop,
    output logic [7:0]       oMop,
    input  logic [7:0]       iFlowIdx,
    input  logic [7:0]       iCbFlowIdx,
    output logic [UPC_W-1:0] oUopAddr,
    input  logic [12:0]      iUop,
    input  logic             iZFlag,
    input  logic             iStall,
    output logic             oUopValid,
    output logic [4:0]       oOp,
    output logic [3:0]       oOperand,
    output logic             oPcInc,
    output logic             oFlagsUpdate,
    output logic             oEof,
    output logic             oMopReq,
    output logic             oError
);

    useq_state_t      state;
    logic [UPC_W-1:0] upc;
    logic [7:0]       cnt;

    logic [3:0] flow;
    logic [4:0] op;
    logic [3:0] opr;
    logic       dec_inc;
    logic       dec_eof;
    logic       dec_fu;
    logic       is_jcb;
    logic       wdog;

    assign flow     = iUop[FLOW_HI:FLOW_LO];
    assign op       = iUop[OP_HI:OP_LO];
    assign opr      = iUop[OPR_HI:OPR_LO];
    assign is_jcb   = (op == OP_JCB);
    assign wdog     = (cnt == 8'(MAX_FLOW_LEN));
    assign oUopAddr = upc;

    dzcpu_useq_flowdec u_flowdec (
        .flow  (flow),
        .zflag (iZFlag),
        .inc   (dec_inc),
        .eof   (dec_eof),
        .fu    (dec_fu)
    );

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state        <= ST_IDLE;
            upc          <= '0;
            cnt          <= '0;
            oMop         <= '0;
            oUopValid    <= 1'b0;
            oOp          <= '0;
            oOperand     <= '0;
            oPcInc       <= 1'b0;
            oFlagsUpdate <= 1'b0;
            oEof         <= 1'b0;
            oMopReq      <= 1'b1;
            oError       <= 1'b0;
        end else begin
            oUopValid    <= 1'b0;
            oPcInc       <= 1'b0;
            oFlagsUpdate <= 1'b0;
            oEof         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iMopValid) begin
                        oMop    <= iMop;
                        oMopReq <= 1'b0;
                        state   <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH: begin
                    upc   <= UPC_W'(iFlowIdx);
                    cnt   <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!iStall) begin
                        // runaway flow: drop the uop at the limit
                        if (wdog) begin
                            oError  <= 1'b1;
                            oMopReq <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            oUopValid    <= 1'b1;
                            oOp          <= op;
                            oOperand     <= opr;
                            oPcInc       <= dec_inc;
                            oFlagsUpdate <= dec_fu;
                            oEof         <= dec_eof;
                            cnt          <= cnt + 8'd1;
                            if (is_jcb) begin
                                upc <= UPC_W'(iCbFlowIdx);
                            end else begin
                                upc <= upc + UPC_W'(1);
                            end
                            if (dec_eof) begin
                                oMopReq <= 1'b1;
                                state   <= ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    oMopReq <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq: ROM/LUT models, flow runs,
// stall, CB redirect, wrap, watchdog and mid-flow reset.
module tb_dzcpu_useq;
    import dzcpu_useq_defs::*;

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic        iMopValid = 1'b0;
    logic [7:0]  iMop = 8'h00;
    logic [7:0]  oMop;
    logic [7:0]  iFlowIdx;
    logic [7:0]  iCbFlowIdx = 8'h00;
    logic [7:0]  oUopAddr;
    logic [12:0] iUop;
    logic        iZFlag = 1'b0;
    logic        iStall = 1'b0;
    logic        oUopValid;
    logic [4:0]  oOp;
    logic [3:0]  oOperand;
    logic        oPcInc;
    logic        oFlagsUpdate;
    logic        oEof;
    logic        oMopReq;
    logic        oError;

    logic [12:0] rom [256];
    logic [7:0]  lut [256];

    assign iUop     = rom[oUopAddr];
    assign iFlowIdx = lut[oMop];

    dzcpu_useq #(.MAX_FLOW_LEN(16), .UPC_W(8)) dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iMopValid    (iMopValid),
        .iMop         (iMop),
        .oMop         (oMop),
        .iFlowIdx     (iFlowIdx),
        .iCbFlowIdx   (iCbFlowIdx),
        .oUopAddr     (oUopAddr),
        .iUop         (iUop),
        .iZFlag       (iZFlag),
        .iStall       (iStall),
        .oUopValid    (oUopValid),
        .oOp          (oOp),
        .oOperand     (oOperand),
        .oPcInc       (oPcInc),
        .oFlagsUpdate (oFlagsUpdate),
        .oEof         (oEof),
        .oMopReq      (oMopReq),
        .oError       (oError)
    );

    always #5 iClock = ~iClock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic [3:0] f,
                                       input logic [4:0] o,
                                       input logic [3:0] r);
        return {f, o, r};
    endfunction

    logic [7:0] addrs[$];
    int         nu, incs, fus, eofs, gaps, lat, held_bad;
    logic [4:0] last_op;

    function automatic logic [7:0] at(input int i);
        logic [7:0] v;
        v = 8'hxx;
        if (i < addrs.size()) v = addrs[i];
        return v;
    endfunction

    task automatic send_op(input logic [7:0] b);
        int t;
        t = 0;
        while (!oMopReq && t < 50) begin
            @(posedge iClock); #1;
            t++;
        end
        chk("mopreq_wait", oMopReq, 1);
        iMop = b;
        iMopValid = 1'b1;
        @(posedge iClock); #1;
        iMopValid = 1'b0;
    endtask

    // k counts edges after the opcode-accept edge
    task automatic collect(input int budget, input int sf, input int sl);
        logic [7:0] a;
        addrs.delete();
        nu = 0; incs = 0; fus = 0; eofs = 0;
        gaps = 0; lat = -1; held_bad = 0;
        for (int k = 0; k < budget; k++) begin
            iStall = (k >= sf && k < sf + sl);
            a = oUopAddr;
            @(posedge iClock); #1;
            if (oUopValid) begin
                if (lat < 0) lat = k + 2;
                addrs.push_back(a);
                nu++;
                last_op = oOp;
                incs += int'(oPcInc);
                fus  += int'(oFlagsUpdate);
            end else if (lat >= 0) begin
                gaps++;
                if (oOp !== last_op) held_bad++;
                if (oPcInc || oFlagsUpdate || oEof) held_bad++;
            end
            if (oEof) eofs++;
            if (oMopReq) break;
        end
        iStall = 1'b0;
        chk("flow_done", oMopReq, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = mk(FLOW_OP, 5'd2, 4'd0);
            lut[i] = 8'd0;
        end
        rom[1]  = mk(FLOW_INC,     5'd1, 4'd1);
        rom[2]  = mk(FLOW_INC,     5'd2, 4'd2);
        rom[3]  = mk(FLOW_OP,      5'd3, 4'd3);
        rom[4]  = mk(FLOW_INC_EOF, 5'd4, 4'd4);
        rom[13] = mk(FLOW_INC,     5'd6, 4'd0);
        rom[14] = mk(FLOW_OP,      5'd7, 4'd0);
        rom[15] = mk(FLOW_OP,      OP_JCB, 4'd0);
        rom[16] = mk(FLOW_EOF_FU,  5'd8, 4'd5);
        rom[17] = mk(FLOW_INC,       5'd9,  4'd0);
        rom[18] = mk(FLOW_OP,        5'd10, 4'd0);
        rom[19] = mk(FLOW_INC_EOF_Z, 5'd11, 4'd0);
        rom[20] = mk(FLOW_OP,        5'd12, 4'd0);
        rom[21] = mk(FLOW_INC,       5'd13, 4'd0);
        rom[22] = mk(FLOW_INC_EOF,   5'd14, 4'd0);
        rom[24] = mk(FLOW_OP,         5'd15, 4'd0);
        rom[25] = mk(FLOW_INC_EOF_NZ, 5'd16, 4'd0);
        rom[26] = mk(FLOW_EOF,        5'd17, 4'd0);
        rom[40] = mk(FLOW_INC,        5'd18, 4'd0);
        rom[41] = mk(FLOW_INC,        OP_JCB, 4'd0);
        rom[50] = mk(FLOW_INC_EOF_FU, 5'd19, 4'd9);
        rom[60] = mk(FLOW_UPDATE_FLAGS, 5'd20, 4'd0);
        rom[61] = mk(FLOW_NOP,          5'd21, 4'd0);
        rom[62] = mk(4'd12,             5'd22, 4'd0);
        rom[63] = mk(FLOW_EOF,          5'd23, 4'd0);
        rom[254] = mk(FLOW_OP,      5'd24, 4'd0);
        rom[255] = mk(FLOW_INC,     5'd25, 4'd0);
        rom[0]   = mk(FLOW_INC_EOF, 5'd26, 4'd0);
        lut[8'h31] = 8'd1;
        lut[8'h18] = 8'd17;
        lut[8'h20] = 8'd24;
        lut[8'hcb] = 8'd13;
        lut[8'hcc] = 8'd40;
        lut[8'h60] = 8'd60;
        lut[8'h99] = 8'd254;
        lut[8'h77] = 8'd200;

        #12;
        chk("rst_mopreq", oMopReq, 1);
        chk("rst_valid", oUopValid, 0);
        chk("rst_error", oError, 0);
        chk("rst_addr", oUopAddr, 0);
        chk("rst_mop", oMop, 0);
        iReset = 1'b0;
        @(posedge iClock); #1;

        send_op(8'h31);
        collect(30, 1000, 0);
        chk("ld_lat", lat, 3);
        chk("ld_mop", oMop, 8'h31);
        chk("ld_nu", nu, 4);
        chk("ld_a0", at(0), 1);
        chk("ld_a3", at(3), 4);
        chk("ld_inc", incs, 3);
        chk("ld_eof", eofs, 1);
        chk("ld_fu", fus, 0);
        chk("ld_op", last_op, 4);
        chk("ld_opr", oOperand, 4);
        @(posedge iClock); #1;
        chk("ld_req_after", oMopReq, 1);

        iZFlag = 1'b1;
        send_op(8'h18);
        collect(30, 1000, 0);
        chk("jz1_nu", nu, 3);
        chk("jz1_a2", at(2), 19);
        chk("jz1_inc", incs, 2);
        chk("jz1_eof", eofs, 1);

        iZFlag = 1'b0;
        send_op(8'h18);
        collect(30, 1000, 0);
        chk("jz0_nu", nu, 6);
        chk("jz0_a5", at(5), 22);
        chk("jz0_inc", incs, 4);
        chk("jz0_eof", eofs, 1);

        send_op(8'h20);
        collect(30, 1000, 0);
        chk("nz0_nu", nu, 2);
        iZFlag = 1'b1;
        send_op(8'h20);
        collect(30, 1000, 0);
        chk("nz1_nu", nu, 3);
        chk("nz1_a2", at(2), 26);
        iZFlag = 1'b0;

        iCbFlowIdx = 8'd16;
        send_op(8'hcb);
        collect(30, 1000, 0);
        chk("cb_nu", nu, 4);
        chk("cb_a3", at(3), 16);
        chk("cb_fu", fus, 1);
        chk("cb_eof", eofs, 1);

        iCbFlowIdx = 8'd50;
        send_op(8'hcc);
        collect(30, 1000, 0);
        chk("cb2_nu", nu, 3);
        chk("cb2_a2", at(2), 50);
        chk("cb2_inc", incs, 3);
        chk("cb2_fu", fus, 1);
        chk("cb2_opr", oOperand, 9);

        send_op(8'h60);
        collect(30, 1000, 0);
        chk("uf_nu", nu, 4);
        chk("uf_fu", fus, 1);
        chk("uf_inc", incs, 0);
        chk("uf_a3", at(3), 63);

        send_op(8'h99);
        collect(30, 1000, 0);
        chk("wrap_nu", nu, 3);
        chk("wrap_a1", at(1), 255);
        chk("wrap_a2", at(2), 0);

        send_op(8'h31);
        collect(30, 2, 3);
        chk("st_nu", nu, 4);
        chk("st_gaps", gaps, 3);
        chk("st_a1", at(1), 2);
        chk("st_a3", at(3), 4);
        chk("st_hold", held_bad, 0);
        chk("st_inc", incs, 3);
        chk("st_eof", eofs, 1);

        send_op(8'h77);
        collect(40, 1000, 0);
        chk("wd_nu", nu, 16);
        chk("wd_a15", at(15), 215);
        chk("wd_eof", eofs, 0);
        chk("wd_err", oError, 1);
        chk("wd_req", oMopReq, 1);

        send_op(8'h31);
        collect(30, 1000, 0);
        chk("wd2_nu", nu, 4);
        chk("wd2_eof", eofs, 1);
        chk("wd2_err", oError, 1);

        send_op(8'h31);
        begin
            int t;
            t = 0;
            while (!oUopValid && t < 10) begin
                @(posedge iClock); #1;
                t++;
            end
        end
        @(posedge iClock); #1;
        chk("mr_pre_valid", oUopValid, 1);
        #2;
        iReset = 1'b1;
        #1;
        chk("mr_valid", oUopValid, 0);
        chk("mr_eof", oEof, 0);
        chk("mr_req", oMopReq, 1);
        chk("mr_addr", oUopAddr, 0);
        chk("mr_err", oError, 0);
        @(negedge iClock);
        iReset = 1'b0;
        @(posedge iClock); #1;
        chk("mr_after_valid", oUopValid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dzcpu_useq.md
Name: dzcpu_useq

Overview:
Microcode sequencer for the dzcpu core. It latches each fetched opcode and drives it to the main opcode LUT and the CB LUT, which return a flow index. It then steps a micro-PC through the micro-op ROM and issues one registered micro-op per cycle to the datapath. It resolves end-of-flow, conditional end-of-flow on Z, CB-prefix redirection, stalls, and a runaway-flow watchdog.

Parameters:
MAX_FLOW_LEN, 16, maximum uops issued in one flow before the watchdog fires (range 2..255)
UPC_W, 8, micro-PC / ROM address width

Ports:
iClock  in  1  core clock
iReset  in  1  asynchronous, active-high reset
iMopValid  in  1  fetched opcode byte valid on iMop (sampled only while oMopReq=1)
iMop  in  8  fetched opcode byte
oMop  out  8  latched opcode, drives opcode LUT and CB LUT
iFlowIdx  in  8  main LUT result for oMop
iCbFlowIdx  in  8  CB LUT result for the CB byte
oUopAddr  out  UPC_W  micro-PC, drives ROM address
iUop  in  13  ROM word: [12:9] flow code, [8:4] operation, [3:0] operand
iZFlag  in  1  Z flag from datapath
iStall  in  1  datapath/memory stall
oUopValid  out  1  oOp/oOperand valid this cycle
oOp  out  5  registered operation field
oOperand  out  4  registered operand field
oPcInc  out  1  one-cycle pulse: increment PC
oFlagsUpdate  out  1  one-cycle pulse: commit ALU flags
oEof  out  1  one-cycle pulse: last uop of the instruction
oMopReq  out  1  sequencer ready for the next opcode
oError  out  1  sticky watchdog error, cleared only by reset

Behaviour:
- Reset (async): state IDLE; uPC=0; uop counter=0; oMop=0; all outputs 0 except oMopReq=1.
- States: IDLE, DISPATCH, RUN.
- IDLE: oMopReq=1. When iMopValid=1: oMop<=iMop, go to DISPATCH. No uop is issued.
- DISPATCH (1 cycle, so the LUT sees the registered opcode): uPC<=iFlowIdx, counter<=0, go to RUN. Latency from iMopValid to first oUopValid is 3 cycles.
- RUN, ROM is combinational on oUopAddr=uPC. Each non-stalled cycle:
  - register iUop[8:4]->oOp and [3:0]->oOperand, set oUopValid=1;
  - uPC<=uPC+1 (UPC_W-bit wrap);
  - counter++.
- Flow-code decode (package constants):
  - OP=0: no pulse.
  - INC=1: oPcInc.
  - EOF=2: oEof.
  - INC_EOF=3: oPcInc+oEof.
  - EOF_FU=4: oEof+oFlagsUpdate.
  - INC_EOF_FU=5: all three pulses.
  - INC_EOF_Z=6: oPcInc; oEof only if iZFlag=1.
  - INC_EOF_NZ=7: oPcInc; oEof only if iZFlag=0.
  - UPDATE_FLAGS=8: oFlagsUpdate.
  - NOP=9: no pulse.
  - 10..15: treated as OP.
- Conditional flows always issue their operation field. Only the end of flow is conditional.
- The CB redirect is an operation, not a flow code. If the operation equals OP_JCB, the uop is issued, its flow-code pulses apply, and uPC<=iCbFlowIdx instead of uPC+1. The counter is not reset.
- When oEof fires: state<=IDLE, oMopReq=1 from the next cycle. Back-to-back opcodes therefore cost 2 overhead cycles.
- Pulses and oUopValid are registered: one cycle wide, aligned with oOp/oOperand.
- iStall=1 in RUN:
  - hold uPC, counter and state;
  - oUopValid and all pulses forced 0;
  - oOp/oOperand keep their last value.
- iStall=1 has no effect in IDLE or DISPATCH.
- Watchdog: if the counter reaches MAX_FLOW_LEN without an eof, set oError=1 and force IDLE. The uop at that count is not issued.
- uPC wrap 255->0 within a flow is legal; only the watchdog terminates runaway flows.
- Reset mid-flow: immediate return to reset values. No pulse is emitted in that cycle.

Decomposition:
- Shared package dzcpu_useq_defs: flow-code constants (FLOW_OP..FLOW_NOP), OP_JCB value, state encodings, iUop field slice indices.
- Operation/operand encodings already in the core's opcode-definition include are reused, not duplicated.
- One natural sub-module, dzcpu_useq_flowdec: combinational flow code + iZFlag -> {inc, eof, fu}.

Test Plan:
- 4-uop load flow (flow codes INC,INC,OP,INC_EOF) at index 1: iMopValid with opcode 0x31, iFlowIdx=1 -> oUopAddr 1,2,3,4; 3 oPcInc pulses; oEof on the 4th uop; oMopReq=1 the cycle after.
- Relative jump flow at index 17, third uop INC_EOF_Z, iZFlag=1 -> oEof on the 3rd uop, 3 uops issued. Repeat with iZFlag=0 -> 6 uops issued, oEof on uop at 22.
- CB flow at 13: third uop op=OP_JCB, iCbFlowIdx=16, ROM[16]=EOF_FU -> next oUopAddr=16; oEof+oFlagsUpdate; total 4 uops.
- iStall high 3 cycles mid-flow -> oUopAddr frozen, oUopValid=0 for exactly 3 cycles, flow completes with the same uop sequence.
- ROM filled with OP from index 200, MAX_FLOW_LEN=16 -> exactly 16 uops then oError=1, oMopReq=1. A further opcode still dispatches normally; oError stays 1 until iReset.
- iReset asserted on the 2nd uop of a flow -> same cycle: oUopValid=0, oEof=0, oMopReq=1, oUopAddr=0.
